// File: rtl/font_rom_arbiter.sv
// Round-robin arbiter sharing one glyph ROM among N_REQ text renderers.
// Grants are registered; returned rows are routed back after ROM_LAT cycles.
module font_rom_arbiter #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned AW      = 10,
   parameter int unsigned DW      = 32,
   parameter int unsigned ROM_LAT = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ*AW-1:0] req_addr,
   output logic [N_REQ-1:0]    gnt,
   output logic [N_REQ-1:0]    rd_valid,
   output logic [DW-1:0]       rd_data,
   output logic [AW-1:0]       rom_adr,
   output logic                rom_en,
   input  logic [DW-1:0]       rom_data
);

   localparam int unsigned   PW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [PW:0]   NREQ_W  = (PW+1)'(N_REQ);
   localparam logic [PW-1:0] LAST_ID = PW'(N_REQ - 1);

   logic [PW-1:0]    ptr_q, ptr_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [PW-1:0]    gnt_id_q, gnt_id_d;
   logic [AW-1:0]    rom_adr_q, rom_adr_d;
   logic             rom_en_q, rom_en_d;

   logic [N_REQ-1:0] eligible;
   logic             win_found;
   logic [PW-1:0]    win_id;
   logic [PW:0]      scan_idx;

   logic [ROM_LAT-1:0] pipe_vld_q;
   logic [PW-1:0]      pipe_id_q [ROM_LAT];

   // A port is masked during its own grant cycle so a held request is not granted twice.
   assign eligible = req & ~gnt_q;

   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      scan_idx  = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         scan_idx = {1'b0, ptr_q} + (PW+1)'(i);
         if (scan_idx >= NREQ_W) begin
            scan_idx = scan_idx - NREQ_W;
         end
         if (!win_found && eligible[scan_idx[PW-1:0]]) begin
            win_found = 1'b1;
            win_id    = scan_idx[PW-1:0];
         end
      end
   end

   always_comb begin
      gnt_d     = '0;
      gnt_id_d  = gnt_id_q;
      rom_adr_d = rom_adr_q;
      rom_en_d  = 1'b0;
      ptr_d     = ptr_q;
      if (win_found) begin
         gnt_d[win_id] = 1'b1;
         gnt_id_d      = win_id;
         rom_adr_d     = req_addr[win_id*AW +: AW];
         rom_en_d      = 1'b1;
         ptr_d         = (win_id == LAST_ID) ? '0 : win_id + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q     <= '0;
         gnt_q     <= '0;
         gnt_id_q  <= '0;
         rom_adr_q <= '0;
         rom_en_q  <= 1'b0;
      end else begin
         ptr_q     <= ptr_d;
         gnt_q     <= gnt_d;
         gnt_id_q  <= gnt_id_d;
         rom_adr_q <= rom_adr_d;
         rom_en_q  <= rom_en_d;
      end
   end

   // Return pipeline: stage 0 holds the request issued to the ROM in the previous cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < ROM_LAT; i++) begin
            pipe_vld_q[i] <= 1'b0;
            pipe_id_q[i]  <= '0;
         end
      end else begin
         pipe_vld_q[0] <= rom_en_q;
         pipe_id_q[0]  <= gnt_id_q;
         for (int unsigned i = 1; i < ROM_LAT; i++) begin
            pipe_vld_q[i] <= pipe_vld_q[i-1];
            pipe_id_q[i]  <= pipe_id_q[i-1];
         end
      end
   end

   always_comb begin
      rd_valid = '0;
      if (pipe_vld_q[ROM_LAT-1]) begin
         rd_valid[pipe_id_q[ROM_LAT-1]] = 1'b1;
      end
   end

   assign rd_data = (|rd_valid) ? rom_data : '0;
   assign gnt     = gnt_q;
   assign rom_adr = rom_adr_q;
   assign rom_en  = rom_en_q;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Bench for font_rom_arbiter: three configurations (4/lat1, 4/lat3, 3/lat1) driven
// with directed and random requests, checked against a schedule-based reference model.
module tb_font_rom_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [7:0] req_a  [3];
   logic [9:0] addr_a [3][8];

   logic [3:0]  req0, req1;
   logic [2:0]  req2;
   logic [39:0] ra0, ra1;
   logic [29:0] ra2;

   always_comb begin
      req0 = req_a[0][3:0];
      req1 = req_a[1][3:0];
      req2 = req_a[2][2:0];
      ra0  = '0;
      ra1  = '0;
      ra2  = '0;
      for (int k = 0; k < 4; k++) begin
         ra0[k*10 +: 10] = addr_a[0][k];
         ra1[k*10 +: 10] = addr_a[1][k];
      end
      for (int k = 0; k < 3; k++) begin
         ra2[k*10 +: 10] = addr_a[2][k];
      end
   end

   logic [3:0]  gnt0, gnt1, rdv0, rdv1;
   logic [2:0]  gnt2, rdv2;
   logic [31:0] rdd0, rdd1, rdd2, romd0, romd1, romd2;
   logic [9:0]  adr0, adr1, adr2;
   logic        en0, en1, en2;

   font_rom_arbiter #(.N_REQ(4), .AW(10), .DW(32), .ROM_LAT(1)) u_dut0 (
      .clk(clk), .rst(rst), .req(req0), .req_addr(ra0), .gnt(gnt0), .rd_valid(rdv0),
      .rd_data(rdd0), .rom_adr(adr0), .rom_en(en0), .rom_data(romd0));
   font_rom_arbiter #(.N_REQ(4), .AW(10), .DW(32), .ROM_LAT(3)) u_dut1 (
      .clk(clk), .rst(rst), .req(req1), .req_addr(ra1), .gnt(gnt1), .rd_valid(rdv1),
      .rd_data(rdd1), .rom_adr(adr1), .rom_en(en1), .rom_data(romd1));
   font_rom_arbiter #(.N_REQ(3), .AW(10), .DW(32), .ROM_LAT(1)) u_dut2 (
      .clk(clk), .rst(rst), .req(req2), .req_addr(ra2), .gnt(gnt2), .rd_valid(rdv2),
      .rd_data(rdd2), .rom_adr(adr2), .rom_en(en2), .rom_data(romd2));

   function automatic logic [31:0] rom_f(input logic [9:0] a);
      return {~a, a, 12'hA5C};
   endfunction

   // Synchronous ROMs of latency 1, 3 and 1.
   logic [9:0] rp0, rp2;
   logic [9:0] rp1 [3];
   always_ff @(posedge clk) begin
      rp0    <= adr0;
      rp2    <= adr2;
      rp1[0] <= adr1;
      rp1[1] <= rp1[0];
      rp1[2] <= rp1[1];
   end
   assign romd0 = rom_f(rp0);
   assign romd1 = rom_f(rp1[2]);
   assign romd2 = rom_f(rp2);

   // Reference model state
   int         m_n   [3] = '{4, 4, 3};
   int         m_lat [3] = '{1, 3, 1};
   int         m_ptr [3];
   int         m_gnt [3];
   logic       m_en  [3];
   logic [9:0] m_adr [3];
   bit         slot_v [3][8];
   int         slot_p [3][8];
   logic [9:0] slot_a [3][8];
   int         wait_c [3][8];
   int         cyc, tests, fails;

   task automatic model_edge(input int i, input logic r);
      int w;
      int k;
      int s;
      if (r) begin
         m_ptr[i] = 0;
         m_gnt[i] = -1;
         m_en[i]  = 1'b0;
         m_adr[i] = '0;
         for (int j = 0; j < 8; j++) slot_v[i][j] = 1'b0;
         return;
      end
      w = -1;
      for (int j = 0; j < m_n[i]; j++) begin
         k = (m_ptr[i] + j) % m_n[i];
         if (w < 0 && req_a[i][k] && m_gnt[i] != k) w = k;
      end
      if (w >= 0) begin
         m_adr[i] = addr_a[i][w];
         m_en[i]  = 1'b1;
         m_ptr[i] = (w + 1) % m_n[i];
         s = (cyc + 1 + m_lat[i]) % 8;
         slot_v[i][s] = 1'b1;
         slot_p[i][s] = w;
         slot_a[i][s] = addr_a[i][w];
      end else begin
         m_en[i] = 1'b0;
      end
      m_gnt[i] = w;
   endtask

   task automatic check(input int i, input logic r);
      logic [7:0]  og, orv, eg, erv;
      logic [31:0] od;
      logic [9:0]  oa;
      logic        oe;
      int          s;
      case (i)
         0: begin og = 8'(gnt0); orv = 8'(rdv0); od = rdd0; oa = adr0; oe = en0; end
         1: begin og = 8'(gnt1); orv = 8'(rdv1); od = rdd1; oa = adr1; oe = en1; end
         default: begin og = 8'(gnt2); orv = 8'(rdv2); od = rdd2; oa = adr2; oe = en2; end
      endcase
      eg = (m_gnt[i] < 0) ? 8'h00 : 8'h01 << m_gnt[i];
      tests++;
      assert (og === eg) else begin
         fails++;
         $error("FAIL gnt inst%0d cyc%0d: got %b, expected %b", i, cyc, og, eg);
      end
      tests++;
      assert (oe === m_en[i]) else begin
         fails++;
         $error("FAIL rom_en inst%0d cyc%0d: got %b, expected %b", i, cyc, oe, m_en[i]);
      end
      tests++;
      assert (oa === m_adr[i]) else begin
         fails++;
         $error("FAIL rom_adr inst%0d cyc%0d: got %h, expected %h", i, cyc, oa, m_adr[i]);
      end
      s   = cyc % 8;
      erv = slot_v[i][s] ? 8'h01 << slot_p[i][s] : 8'h00;
      tests++;
      assert (orv === erv) else begin
         fails++;
         $error("FAIL rd_valid inst%0d cyc%0d: got %b, expected %b", i, cyc, orv, erv);
      end
      if (slot_v[i][s]) begin
         tests++;
         assert (od === rom_f(slot_a[i][s])) else begin
            fails++;
            $error("FAIL rd_data inst%0d cyc%0d: got %h, expected %h", i, cyc, od,
                   rom_f(slot_a[i][s]));
         end
      end
      slot_v[i][s] = 1'b0;
      for (int k = 0; k < m_n[i]; k++) begin
         if (r || og[k] || !req_a[i][k]) wait_c[i][k] = 0;
         else wait_c[i][k]++;
         tests++;
         assert (wait_c[i][k] <= m_n[i]) else begin
            fails++;
            $error("FAIL starve inst%0d port%0d: waited %0d, limit %0d", i, k, wait_c[i][k],
                   m_n[i]);
         end
      end
   endtask

   task automatic step(input logic r);
      rst = r;
      for (int i = 0; i < 3; i++) model_edge(i, r);
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 3; i++) check(i, r);
   endtask

   task automatic set_req(input logic [7:0] v);
      for (int i = 0; i < 3; i++) req_a[i] = v;
   endtask

   // Requesters drop a request only once its grant is visible.
   task automatic drain();
      repeat (8) begin
         for (int i = 0; i < 3; i++)
            for (int k = 0; k < 8; k++)
               if (req_a[i][k] && m_gnt[i] == k) req_a[i][k] = 1'b0;
         step(1'b0);
      end
      set_req(8'h00);
   endtask

   task automatic rand_stim();
      for (int i = 0; i < 3; i++)
         for (int k = 0; k < m_n[i]; k++)
            if (!req_a[i][k] || m_gnt[i] == k) begin
               req_a[i][k]  = ($urandom_range(0, 99) < 65);
               addr_a[i][k] = 10'($urandom);
            end
   endtask

   initial begin
      cyc   = 0;
      tests = 0;
      fails = 0;
      for (int i = 0; i < 3; i++) begin
         req_a[i] = '0;
         m_ptr[i] = 0;
         m_gnt[i] = -1;
         m_en[i]  = 1'b0;
         m_adr[i] = '0;
         for (int k = 0; k < 8; k++) begin
            addr_a[i][k] = '0;
            slot_v[i][k] = 1'b0;
            wait_c[i][k] = 0;
         end
      end

      step(1'b1);
      step(1'b1);

      // Single request on port 2
      for (int i = 0; i < 3; i++) addr_a[i][2] = 10'h1A0;
      set_req(8'b0100);
      drain();

      // Pointer wrap: ptr=3 then ptr=1 with ports 0 and 3 requesting
      set_req(8'b1001);
      drain();
      set_req(8'b1001);
      drain();

      // All ports requesting continuously
      for (int i = 0; i < 3; i++)
         for (int k = 0; k < 4; k++) addr_a[i][k] = 10'(k * 'h40);
      set_req(8'b1111);
      repeat (10) step(1'b0);
      drain();

      // Port 1 held alone
      set_req(8'b0010);
      repeat (7) step(1'b0);
      drain();

      // Reset with reads in flight
      set_req(8'b0101);
      step(1'b0);
      step(1'b0);
      set_req(8'h00);
      step(1'b1);
      repeat (4) step(1'b0);

      // Random traffic with occasional resets
      repeat (400) begin
         if ($urandom_range(0, 59) == 0) begin
            set_req(8'h00);
            step(1'b1);
         end else begin
            rand_stim();
            step(1'b0);
         end
      end
      drain();
      repeat (4) step(1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
